pll_underclock_seq: RTL and testbench
=====================================

PLL_UNDERCLOCK_SEQ -- requirements
Module: pll_underclock_seq

Interface
REQ-001 SHALL have parameter FRAC_NATIVE, default 32'd3639383488: fractional-divider word for native clock.
REQ-002 SHALL have parameter FRAC_UNDER, default 32'd3262113561: fractional-divider word for the ~1% underclock.
REQ-003 SHALL have parameter LOCK_STABLE, default 16: consecutive locked cycles that count as settled.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 2^20: cycle limit for lock wait.
REQ-005 SHALL have port clk_50m, input, 1 bit: sole clock, which is also the PLL management clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port underclock, input, 1 bit: requested mode from OSD status, asynchronous to clk_50m.
REQ-008 SHALL have port locked, input, 1 bit: PLL lock indicator, asynchronous.
REQ-009 SHALL have port mgmt_waitrequest, input, 1 bit: reconfig-controller stall.
REQ-010 SHALL have port mgmt_write, output, 1 bit: write strobe.
REQ-011 SHALL have port mgmt_address, output, 6 bits: register address.
REQ-012 SHALL have port mgmt_writedata, output, 32 bits: register data.
REQ-013 SHALL have port busy, output, 1 bit: high while a sequence runs.
REQ-014 SHALL have port applied, output, 1 bit: mode last successfully applied (1 = underclock).
REQ-015 SHALL have port lock_err, output, 1 bit: sticky lock-timeout flag.

Function
REQ-016 underclock and locked SHALL pass through 2-flop synchronizers.
REQ-017 A mode change SHALL be accepted only when two consecutive synchronized underclock samples are equal and differ from the target register; acceptance loads the target.
REQ-018 States SHALL be IDLE, MODE, FRAC, START, WAIT_LOCK, GAP.
REQ-019 IDLE -> MODE SHALL occur the cycle after target != applied.
REQ-020 MODE SHALL write address 0, data 0 (waitrequest mode).
REQ-021 FRAC SHALL write address 7, data FRAC_UNDER if target=1, else FRAC_NATIVE.
REQ-022 START SHALL write address 2, data 0.
REQ-023 Each write SHALL hold mgmt_write=1 with stable address/data until a cycle with mgmt_waitrequest=0; that cycle completes the transfer, and the next state is entered on the following edge.
REQ-024 Between consecutive writes SHALL be exactly one cycle with mgmt_write=0.
REQ-025 WAIT_LOCK SHALL require LOCK_STABLE consecutive cycles of synchronized locked=1; any locked=0 restarts the count.
REQ-026 On settle in WAIT_LOCK: applied <= mode used for FRAC; go to GAP.
REQ-027 On reaching LOCK_TIMEOUT cycles in WAIT_LOCK: set lock_err, leave applied unchanged, go to GAP.
REQ-028 GAP SHALL last one cycle, then return to IDLE.
REQ-029 If target changes mid-sequence, the running sequence SHALL finish with its latched FRAC word; IDLE then re-runs because target != applied.
REQ-030 A timed-out mode SHALL NOT be retried until target changes again.
REQ-031 lock_err SHALL clear only on reset.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 mgmt_write=0 SHALL hold in IDLE, WAIT_LOCK, and GAP.

Reset
REQ-034 While reset=0, all state SHALL clear asynchronously: state=IDLE, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, applied=0, target=0, lock_err=0, counters=0.
REQ-035 Reset mid-write SHALL drop mgmt_write immediately.
REQ-036 After reset release with underclock=1, a full sequence SHALL run once the stability rule accepts it.

Structure
REQ-037 Register addresses (MODE=0, FRAC=7, START=2), state enum, and default FRAC words SHALL live in shared package tp84_pll_pkg.
REQ-038 The sync-plus-stability logic SHALL be sub-module sync_stable.
REQ-039 The FSM, write handshake, and lock counter SHALL stay in pll_underclock_seq.

Verification
REQ-040 Scenario: reset release, underclock=1, waitrequest=0 -> writes (0,0), (7,3262113561), (2,0), each 1 cycle with 1-cycle gaps; locked high 16 cycles -> applied=1, busy=0.
REQ-041 Scenario: waitrequest=1 for 5 cycles during the FRAC write -> mgmt_write and data stable 6 cycles, one transfer only.
REQ-042 Scenario: underclock toggles 1->0 during the START write -> first sequence completes with 3262113561, then second sequence writes 3639383488, final applied=0.
REQ-043 Scenario: locked stuck 0 after START -> lock_err=1 at LOCK_TIMEOUT, applied unchanged, no further writes.
REQ-044 Scenario: a 1-cycle glitch on underclock -> no write issued.
REQ-045 Scenario: reset asserted while mgmt_write=1 -> mgmt_write=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/tp84_pll_pkg.sv
// Shared constants and types for the PLL underclock sequencer: reconfig
// register addresses, default fractional-divider words and the FSM states.
package tp84_pll_pkg;

  localparam logic [5:0]  ADDR_MODE  = 6'd0;
  localparam logic [5:0]  ADDR_FRAC  = 6'd7;
  localparam logic [5:0]  ADDR_START = 6'd2;

  localparam logic [31:0] FRAC_NATIVE_DEF = 32'd3639383488;
  localparam logic [31:0] FRAC_UNDER_DEF  = 32'd3262113561;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MODE      = 3'd1,
    S_FRAC      = 3'd2,
    S_START     = 3'd3,
    S_WAIT_LOCK = 3'd4,
    S_GAP       = 3'd5
  } state_e;

  // Pick the fractional word for a requested mode (1 = underclock).
  function automatic logic [31:0] frac_word(input logic        mode,
                                            input logic [31:0] native,
                                            input logic [31:0] under);
    return mode ? under : native;
  endfunction

endpackage

// File: rtl/sync_stable.sv
// Two-flop synchronizers for the asynchronous mode request and PLL lock,
// plus the target register: a new mode is taken only after two equal
// consecutive synchronized samples that differ from the current target.
module sync_stable (
  input  logic clk,
  input  logic rst_n,
  input  logic underclock,
  input  logic locked,
  output logic target,
  output logic locked_s
);

  logic [1:0] uc_sync_q;
  logic [1:0] lk_sync_q;
  logic       uc_prev_q;
  logic       target_q;
  logic       target_d;

  // Accept a new target only when the synchronized request has held for two samples.
  always_comb begin
    target_d = target_q;
    if ((uc_sync_q[1] == uc_prev_q) && (uc_sync_q[1] != target_q)) begin
      target_d = uc_sync_q[1];
    end
  end

  // Synchronizer chains, previous-sample register and target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uc_sync_q <= 2'b00;
      lk_sync_q <= 2'b00;
      uc_prev_q <= 1'b0;
      target_q  <= 1'b0;
    end else begin
      uc_sync_q <= {uc_sync_q[0], underclock};
      lk_sync_q <= {lk_sync_q[0], locked};
      uc_prev_q <= uc_sync_q[1];
      target_q  <= target_d;
    end
  end

  assign target   = target_q;
  assign locked_s = lk_sync_q[1];

endmodule

// File: rtl/pll_underclock_seq.sv
// Sequencer that retunes a fractional PLL between native and ~1% underclock
// through its reconfig controller: MODE, FRAC and START writes, then waits for
// a settled lock (or a timeout) before recording the applied mode.
//
// Write handshake: mgmt_write is the valid; mgmt_waitrequest=0 is the ready.
// While mgmt_write=1 the address and data stay constant; a cycle with
// mgmt_write=1 and mgmt_waitrequest=0 completes exactly one transfer, and the
// next write state always begins with one cycle of mgmt_write=0.
module pll_underclock_seq
  import tp84_pll_pkg::*;
#(
  parameter logic [31:0] FRAC_NATIVE  = FRAC_NATIVE_DEF,
  parameter logic [31:0] FRAC_UNDER   = FRAC_UNDER_DEF,
  parameter int          LOCK_STABLE  = 16,
  parameter int          LOCK_TIMEOUT = 2 ** 20
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        underclock,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        applied,
  output logic        lock_err,
  output logic [2:0]  dbg_state
);

  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  logic target;
  logic locked_s;

  sync_stable u_sync (
    .clk        (clk_50m),
    .rst_n      (reset),
    .underclock (underclock),
    .locked     (locked),
    .target     (target),
    .locked_s   (locked_s)
  );

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [5:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               mode_q, mode_d;
  logic               applied_q, applied_d;
  logic               lock_err_q, lock_err_d;
  logic               fail_q, fail_d;
  logic               fail_mode_q, fail_mode_d;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  // Next-state, write handshake, lock counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mode_d      = mode_q;
    applied_d   = applied_q;
    lock_err_d  = lock_err_q;
    fail_d      = fail_q;
    fail_mode_d = fail_mode_q;
    stb_d       = stb_q;
    tmo_d       = tmo_q;

    // A mode that timed out is blocked only until the target moves away from it.
    if (fail_q && (target != fail_mode_q)) begin
      fail_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if ((target != applied_q) && !(fail_q && (target == fail_mode_q))) begin
          state_d = S_MODE;
          mode_d  = target;
        end
      end
      S_MODE: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_MODE;
          data_d  = 32'd0;
        end else if (!mgmt_waitrequest) begin
          write_d = 1'b0;
          state_d = S_FRAC;
        end
      end
      S_FRAC: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_FRAC;
          data_d  = frac_word(mode_q, FRAC_NATIVE, FRAC_UNDER);
        end else if (!mgmt_waitrequest) begin
          write_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_START;
          data_d  = 32'd0;
        end else if (!mgmt_waitrequest) begin
          write_d = 1'b0;
          stb_d   = '0;
          tmo_d   = '0;
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        tmo_d = tmo_q + 1'b1;
        stb_d = locked_s ? (stb_q + 1'b1) : '0;
        if (locked_s && (stb_q == STB_W'(LOCK_STABLE - 1))) begin
          applied_d = mode_q;
          state_d   = S_GAP;
        end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
          lock_err_d  = 1'b1;
          fail_d      = 1'b1;
          fail_mode_d = mode_q;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Single state/output register bank; reset drops the write strobe at once.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= 6'd0;
      data_q      <= 32'd0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      applied_q   <= 1'b0;
      lock_err_q  <= 1'b0;
      fail_q      <= 1'b0;
      fail_mode_q <= 1'b0;
      stb_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      applied_q   <= applied_d;
      lock_err_q  <= lock_err_d;
      fail_q      <= fail_d;
      fail_mode_q <= fail_mode_d;
      stb_q       <= stb_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign busy           = busy_q;
  assign applied        = applied_q;
  assign lock_err       = lock_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pll_underclock_seq.sv
// Bench for pll_underclock_seq: table of mode requests plus hand-written
// sequences for stalls, mid-sequence toggles, glitches, lock restarts and reset.
module tb_pll_underclock_seq;

  localparam logic [31:0] NAT = 32'd3639383488;
  localparam logic [31:0] UND = 32'd3262113561;
  localparam logic [5:0]  A_MODE  = 6'd0;
  localparam logic [5:0]  A_FRAC  = 6'd7;
  localparam logic [5:0]  A_START = 6'd2;

  // ---------------- clock / reset ----------------
  logic clk_50m = 1'b0;
  logic reset = 1'b0;
  logic underclock = 1'b0;
  logic locked = 1'b0;
  logic mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy;
  logic        applied;
  logic        lock_err;
  logic [2:0]  dbg_state;

  always #10 clk_50m = ~clk_50m;

  pll_underclock_seq #(
    .LOCK_STABLE  (16),
    .LOCK_TIMEOUT (200)
  ) dut (
    .clk_50m          (clk_50m),
    .reset            (reset),
    .underclock       (underclock),
    .locked           (locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .busy             (busy),
    .applied          (applied),
    .lock_err         (lock_err),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  logic [37:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic mode);
    exp_q.push_back({A_MODE, 32'd0});
    exp_q.push_back({A_FRAC, mode ? UND : NAT});
    exp_q.push_back({A_START, 32'd0});
  endtask

  // Transfer monitor: order/content, hold stability, write length and gaps.
  int          run_len = 0;
  int          gap_len = 0;
  int          seq_writes = 0;
  logic        prev_write = 1'b0;
  logic [5:0]  prev_addr = 6'd0;
  logic [31:0] prev_data = 32'd0;
  logic        stall_frac = 1'b0;
  logic [37:0] front;

  always @(negedge clk_50m) begin
    if (!reset) begin
      prev_write = 1'b0;
      run_len    = 0;
      gap_len    = 0;
      seq_writes = 0;
    end else begin
      if (!busy) seq_writes = 0;
      if (mgmt_write) begin
        if (!prev_write) begin
          if (seq_writes > 0) check("gap between writes", gap_len, 1);
          run_len = 0;
        end else begin
          check("stable addr/data while stalled", {mgmt_address, mgmt_writedata}, {prev_addr, prev_data});
        end
        run_len++;
        gap_len = 0;
        if (!mgmt_waitrequest) begin
          n_xfer++;
          seq_writes++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected write: addr %0d data %0d, expected no write", mgmt_address, mgmt_writedata);
          end else begin
            front = exp_q.pop_front();
            check("write addr/data", {mgmt_address, mgmt_writedata}, front);
          end
          check("write length", run_len, (stall_frac && mgmt_address == A_FRAC) ? 6 : 1);
        end
      end else begin
        gap_len++;
      end
      prev_write = mgmt_write;
      prev_addr  = mgmt_address;
      prev_data  = mgmt_writedata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk_50m); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk_50m);
    @(posedge clk_50m); #1;
    reset = 1'b1;
  endtask

  task automatic wait_quiet(input string name);
    int q;
    int c;
    q = 0;
    c = 0;
    while (q < 12 && c < 3000) begin
      @(negedge clk_50m);
      c++;
      if (!busy) q++; else q = 0;
    end
    if (q < 12) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: busy still %0b after cycle budget, expected idle", name, busy);
    end
  endtask

  task automatic wait_write(input logic [5:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_50m);
      if (mgmt_write && mgmt_address == a) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("write to addr %0d seen", a), ok, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic uc;
    logic lk;
    logic runs;
    logic exp_applied;
    logic exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached, expected summary first");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int x0;

    vecs[0] = '{uc: 1'b1, lk: 1'b1, runs: 1'b1, exp_applied: 1'b1, exp_err: 1'b0};
    vecs[1] = '{uc: 1'b0, lk: 1'b1, runs: 1'b1, exp_applied: 1'b0, exp_err: 1'b0};
    vecs[2] = '{uc: 1'b1, lk: 1'b1, runs: 1'b1, exp_applied: 1'b1, exp_err: 1'b0};
    vecs[3] = '{uc: 1'b1, lk: 1'b1, runs: 1'b0, exp_applied: 1'b1, exp_err: 1'b0};
    vecs[4] = '{uc: 1'b0, lk: 1'b0, runs: 1'b1, exp_applied: 1'b1, exp_err: 1'b1};
    vecs[5] = '{uc: 1'b1, lk: 1'b1, runs: 1'b0, exp_applied: 1'b1, exp_err: 1'b1};
    vecs[6] = '{uc: 1'b0, lk: 1'b1, runs: 1'b1, exp_applied: 1'b0, exp_err: 1'b1};

    // Reset state.
    repeat (3) @(negedge clk_50m);
    check("reset mgmt_write", mgmt_write, 0);
    check("reset mgmt_address", mgmt_address, 0);
    check("reset mgmt_writedata", mgmt_writedata, 0);
    check("reset busy", busy, 0);
    check("reset applied", applied, 0);
    check("reset lock_err", lock_err, 0);
    check("reset state", dbg_state, 0);
    @(posedge clk_50m); #1;
    reset = 1'b1;

    // Table of mode requests.
    for (int i = 0; i < 7; i++) begin
      x0 = n_xfer;
      if (vecs[i].runs) push_seq(vecs[i].uc);
      @(posedge clk_50m); #1;
      locked     = vecs[i].lk;
      underclock = vecs[i].uc;
      wait_quiet($sformatf("vec%0d idle", i));
      repeat (60) @(negedge clk_50m);
      check($sformatf("vec%0d applied", i), applied, vecs[i].exp_applied);
      check($sformatf("vec%0d lock_err", i), lock_err, vecs[i].exp_err);
      check($sformatf("vec%0d busy", i), busy, 0);
      check($sformatf("vec%0d transfers", i), n_xfer - x0, vecs[i].runs ? 3 : 0);
      check($sformatf("vec%0d pending", i), exp_q.size(), 0);
    end

    // A: reset release with underclock=1, FRAC write stalled 5 cycles.
    underclock = 1'b1;
    locked     = 1'b1;
    do_reset();
    x0 = n_xfer;
    push_seq(1'b1);
    stall_frac = 1'b1;
    wait_write(A_MODE, ok);
    @(posedge clk_50m); #1;
    mgmt_waitrequest = 1'b1;
    wait_write(A_FRAC, ok);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk_50m);
      check($sformatf("stall cycle %0d write", k), mgmt_write, 1);
    end
    @(posedge clk_50m); #1;
    mgmt_waitrequest = 1'b0;
    wait_quiet("stall idle");
    stall_frac = 1'b0;
    check("stall applied", applied, 1);
    check("stall lock_err", lock_err, 0);
    check("stall transfers", n_xfer - x0, 3);

    // B: request toggles 1->0 during the START write.
    do_reset();
    x0 = n_xfer;
    push_seq(1'b1);
    push_seq(1'b0);
    wait_write(A_START, ok);
    @(posedge clk_50m); #1;
    underclock = 1'b0;
    wait_quiet("toggle idle");
    check("toggle applied", applied, 0);
    check("toggle transfers", n_xfer - x0, 6);
    check("toggle pending", exp_q.size(), 0);

    // C: one-cycle glitch on the request.
    x0 = n_xfer;
    @(posedge clk_50m); #1;
    underclock = 1'b1;
    @(posedge clk_50m); #1;
    underclock = 1'b0;
    repeat (30) @(negedge clk_50m);
    check("glitch transfers", n_xfer - x0, 0);
    check("glitch busy", busy, 0);
    check("glitch applied", applied, 0);

    // D: a drop in lock restarts the settle count.
    locked = 1'b0;
    push_seq(1'b1);
    @(posedge clk_50m); #1;
    underclock = 1'b1;
    wait_write(A_START, ok);
    @(posedge clk_50m); #1;
    locked = 1'b1;
    repeat (10) @(posedge clk_50m);
    #1 locked = 1'b0;
    repeat (3) @(posedge clk_50m);
    #1 locked = 1'b1;
    repeat (12) @(negedge clk_50m);
    check("lock restart not yet applied", applied, 0);
    wait_quiet("lock restart idle");
    check("lock restart applied", applied, 1);
    check("lock restart lock_err", lock_err, 0);

    // E: reset asserted while a write is held by waitrequest.
    x0 = n_xfer;
    mgmt_waitrequest = 1'b1;
    @(posedge clk_50m); #1;
    underclock = 1'b0;
    wait_write(A_MODE, ok);
    #3 reset = 1'b0;
    #1;
    check("mid-write reset mgmt_write", mgmt_write, 0);
    check("mid-write reset address", mgmt_address, 0);
    check("mid-write reset data", mgmt_writedata, 0);
    check("mid-write reset busy", busy, 0);
    check("mid-write reset applied", applied, 0);
    check("mid-write reset lock_err", lock_err, 0);
    check("mid-write reset state", dbg_state, 0);
    repeat (2) @(negedge clk_50m);
    mgmt_waitrequest = 1'b0;
    @(posedge clk_50m); #1;
    reset = 1'b1;
    repeat (30) @(negedge clk_50m);
    check("post reset transfers", n_xfer - x0, 0);
    check("post reset busy", busy, 0);
    check("final pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
